// File: rtl/spi_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_channel_sequencer
// Description : SPI master (CPOL=0, CPHA=1, MSB first) that visits each
//               enabled slave in ascending order, FRAME_WORDS words per SS.
//               Optional macro SPI_SEQ_CONTINUOUS_EN adds a 'continuous' input.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_channel_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 2,
    parameter int CLK_DIV     = 2,
    localparam int c_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int c_IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
`ifdef SPI_SEQ_CONTINUOUS_EN
    input  logic                continuous,
`endif
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [WORD_W-1:0]   tx_data,
    output logic                tx_load,
    output logic [c_CH_W-1:0]   tx_ch,
    output logic [c_IDX_W-1:0]  tx_idx,
    output logic [c_CH_W-1:0]   rx_ch,
    output logic [c_IDX_W-1:0]  rx_idx,
    output logic [WORD_W-1:0]   rx_word,
    output logic                rx_valid,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [NUM_CH-1:0]   spi_ss_n,
    output logic                busy,
    output logic                frame_done,
    output logic                cycle_done
);

    localparam int c_BIT_W = $clog2(WORD_W);
    localparam int c_CNT_W = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DESEL = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_mask;
    logic [c_CH_W-1:0]   r_ch;
    logic [c_CH_W-1:0]   r_rx_ch;
    logic [c_CH_W-1:0]   w_first_ch;
    logic [c_CH_W-1:0]   w_next_ch;
    logic                w_first_found;
    logic                w_next_found;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  r_rx_idx;
    logic [c_BIT_W-1:0]  r_bit;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_half;
    logic [WORD_W-1:0]   r_tx_sh;
    logic [WORD_W-1:0]   r_rx_sh;
    logic [WORD_W-1:0]   r_rx_word;
    logic [WORD_W-1:0]   w_rx_shifted;
    logic                r_rx_valid;
    logic                r_zero_done;
    logic                w_go;
    logic                w_restart;
    logic                w_cnt_last;
    logic                w_desel_end;
    logic                w_last_bit;
    logic                w_last_word;

`ifdef SPI_SEQ_CONTINUOUS_EN
    assign w_restart = continuous;
`else
    assign w_restart = 1'b0;
`endif

    // An empty-mask cycle completes in IDLE, so continuous mode restarts from there too.
    assign w_go         = start | (w_restart & r_zero_done);
    assign w_cnt_last   = (r_cnt == c_CNT_W'(CLK_DIV - 1));
    assign w_desel_end  = (r_cnt == c_CNT_W'(2 * CLK_DIV - 1));
    assign w_last_bit   = (r_bit == c_BIT_W'(WORD_W - 1));
    assign w_last_word  = (r_idx == c_IDX_W'(FRAME_WORDS - 1));
    assign w_rx_shifted = {r_rx_sh[WORD_W-2:0], spi_miso};

    assign tx_ch    = r_ch;
    assign tx_idx   = r_idx;
    assign rx_ch    = r_rx_ch;
    assign rx_idx   = r_rx_idx;
    assign rx_word  = r_rx_word;
    assign rx_valid = r_rx_valid;

    always_comb begin
        w_first_found = 1'b0;
        w_first_ch    = '0;
        w_next_found  = 1'b0;
        w_next_ch     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                w_first_found = 1'b1;
                w_first_ch    = c_CH_W'(i);
            end
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_next_found = 1'b1;
                w_next_ch    = c_CH_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_load     = 1'b0;
        spi_sck     = 1'b0;
        spi_mosi    = 1'b0;
        spi_ss_n    = '1;
        busy        = 1'b1;
        frame_done  = 1'b0;
        cycle_done  = r_zero_done;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_go && w_first_found) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                spi_ss_n[r_ch] = 1'b0;
                tx_load        = 1'b1;
                w_state_nxt    = ST_SHIFT;
            end
            ST_SHIFT: begin
                spi_ss_n[r_ch] = 1'b0;
                spi_sck        = ~r_half;
                spi_mosi       = r_tx_sh[WORD_W-1];
                if (w_cnt_last && r_half && w_last_bit)
                    w_state_nxt = w_last_word ? ST_DESEL : ST_GAP;
            end
            ST_GAP: begin
                spi_ss_n[r_ch] = 1'b0;
                if (w_cnt_last) w_state_nxt = ST_LOAD;
            end
            ST_DESEL: begin
                frame_done = (r_cnt == '0);
                if (w_desel_end) w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (w_next_found) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    cycle_done  = 1'b1;
                    w_state_nxt = (w_restart && w_first_found) ? ST_LOAD : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask      <= '0;
            r_ch        <= '0;
            r_idx       <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_half      <= 1'b0;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_rx_word   <= '0;
            r_rx_ch     <= '0;
            r_rx_idx    <= '0;
            r_rx_valid  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_zero_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (w_go) begin
                        r_mask      <= ch_enable;
                        r_ch        <= w_first_ch;
                        r_zero_done <= ~w_first_found;
                    end
                end
                ST_LOAD: begin
                    r_tx_sh <= tx_data;
                    r_cnt   <= '0;
                    r_half  <= 1'b0;
                    r_bit   <= '0;
                end
                ST_SHIFT: begin
                    if (!w_cnt_last) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end else if (!r_half) begin
                        // End of the high half: SCK falls here, so MISO is sampled now.
                        r_cnt   <= '0;
                        r_half  <= 1'b1;
                        r_rx_sh <= w_rx_shifted;
                        if (w_last_bit) begin
                            r_rx_valid <= 1'b1;
                            r_rx_word  <= w_rx_shifted;
                            r_rx_ch    <= r_ch;
                            r_rx_idx   <= r_idx;
                        end
                    end else begin
                        r_cnt  <= '0;
                        r_half <= 1'b0;
                        if (!w_last_bit) begin
                            r_bit   <= r_bit + c_BIT_W'(1);
                            r_tx_sh <= {r_tx_sh[WORD_W-2:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + c_IDX_W'(1);
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_DESEL: begin
                    r_cnt <= w_desel_end ? '0 : r_cnt + c_CNT_W'(1);
                end
                ST_NEXT: begin
                    r_idx <= '0;
                    if (w_next_found) begin
                        r_ch <= w_next_ch;
                    end else if (w_restart && w_first_found) begin
                        r_mask <= ch_enable;
                        r_ch   <= w_first_ch;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_channel_sequencer
// Description : Directed self-checking bench for spi_channel_sequencer with a
//               behavioural SPI slave returning 16'h1234.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_channel_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
`ifdef SPI_SEQ_CONTINUOUS_EN
    logic        continuous = 1'b0;
`endif
    logic [3:0]  ch_enable = 4'h0;
    logic [15:0] tx_data = 16'hA55A;
    logic        tx_load;
    logic [1:0]  tx_ch;
    logic [0:0]  tx_idx;
    logic [1:0]  rx_ch;
    logic [0:0]  rx_idx;
    logic [15:0] rx_word;
    logic        rx_valid;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic [3:0]  spi_ss_n;
    logic        busy;
    logic        frame_done;
    logic        cycle_done;

    spi_channel_sequencer #(
        .NUM_CH      (4),
        .WORD_W      (16),
        .FRAME_WORDS (2),
        .CLK_DIV     (2)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
`ifdef SPI_SEQ_CONTINUOUS_EN
        .continuous (continuous),
`endif
        .ch_enable  (ch_enable),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ch      (tx_ch),
        .tx_idx     (tx_idx),
        .rx_ch      (rx_ch),
        .rx_idx     (rx_idx),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_ss_n   (spi_ss_n),
        .busy       (busy),
        .frame_done (frame_done),
        .cycle_done (cycle_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Monitor and slave model: everything observed on the falling clock edge.
    int n_rise = 0, n_rx = 0, n_txl = 0, n_frame = 0, n_cycle = 0, n_busy = 0;
    int n_sslow = 0, n_onehot_err = 0, n_sck_noss = 0, n_ssfall = 0, n_mosi = 0;
    int n_hirun = 0, hi_run = 0, hi_run_max = 0, hi_run_min = 1000;
    int lo_run = 0, lo_run_max = 0, ss_hi_cnt = 0, bitn = 0;
    logic [15:0] mosi_sh = 16'h0;
    logic [15:0] rx_pat  = 16'h1234;
    logic        sck_d   = 1'b0;
    logic [3:0]  ss_d    = 4'hF;
    logic [3:0]  ss_low_ever = 4'h0;
    logic [15:0] log_rx_word [64];
    logic [1:0]  log_rx_ch   [64];
    logic        log_rx_idx  [64];
    logic [1:0]  log_tx_ch   [64];
    logic [15:0] log_mosi    [64];
    logic [1:0]  log_ss_ch   [64];
    int          log_hirun   [64];

    always @(negedge clock) begin
        if (spi_sck && !sck_d) begin
            n_rise++;
            spi_miso = rx_pat[15 - bitn];
            mosi_sh  = {mosi_sh[14:0], spi_mosi};
            bitn++;
            if (bitn == 16) begin
                if (n_mosi < 64) log_mosi[n_mosi] = mosi_sh;
                n_mosi++;
                bitn = 0;
            end
        end
        if (&spi_ss_n) bitn = 0;

        if (spi_sck) begin
            hi_run++;
        end else if (hi_run > 0) begin
            if (hi_run > hi_run_max) hi_run_max = hi_run;
            if (hi_run < hi_run_min) hi_run_min = hi_run;
            hi_run = 0;
        end
        if (!spi_sck && !(&spi_ss_n)) begin
            lo_run++;
        end else begin
            if (lo_run > lo_run_max) lo_run_max = lo_run;
            lo_run = 0;
        end
        if (busy && (&spi_ss_n)) begin
            ss_hi_cnt++;
        end else begin
            if (ss_hi_cnt > 0 && !(&spi_ss_n) && n_hirun < 64) begin
                log_hirun[n_hirun] = ss_hi_cnt;
                n_hirun++;
            end
            ss_hi_cnt = 0;
        end

        if ($countones(~spi_ss_n) > 1) n_onehot_err++;
        if (spi_sck && (&spi_ss_n)) n_sck_noss++;
        if (!(&spi_ss_n)) n_sslow++;
        ss_low_ever = ss_low_ever | ~spi_ss_n;
        if ((&ss_d) && !(&spi_ss_n)) begin
            for (int c = 0; c < 4; c++)
                if (!spi_ss_n[c] && n_ssfall < 64) log_ss_ch[n_ssfall] = 2'(c);
            n_ssfall++;
        end
        if (rx_valid) begin
            if (n_rx < 64) begin
                log_rx_word[n_rx] = rx_word;
                log_rx_ch[n_rx]   = rx_ch;
                log_rx_idx[n_rx]  = rx_idx[0];
            end
            n_rx++;
        end
        if (tx_load) begin
            if (n_txl < 64) log_tx_ch[n_txl] = tx_ch;
            n_txl++;
        end
        if (frame_done) n_frame++;
        if (cycle_done) n_cycle++;
        if (busy) n_busy++;
        sck_d = spi_sck;
        ss_d  = spi_ss_n;
    end

    task automatic wait_cycle_done(input int target, input int budget, input string tag);
        int k = 0;
        while (n_cycle < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(n_cycle >= target), 32'd1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int k = 0;
        while (n_rise < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(n_rise >= target), 32'd1);
    endtask

    int b_rx, b_txl, b_frame, b_cycle, b_busy, b_rise, b_mosi, b_ssfall, b_sslow, b_hirun;

    task automatic snapshot();
        b_rx = n_rx; b_txl = n_txl; b_frame = n_frame; b_cycle = n_cycle;
        b_busy = n_busy; b_rise = n_rise; b_mosi = n_mosi; b_ssfall = n_ssfall;
        b_sslow = n_sslow; b_hirun = n_hirun;
    endtask

    logic [1:0] exp_ch  [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
    logic       exp_idx [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (3) tick();
        check_eq("rst_ss_n", spi_ss_n, 4'hF);
        check_eq("rst_sck", spi_sck, 0);
        check_eq("rst_mosi", spi_mosi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flags", {tx_load, rx_valid, frame_done, cycle_done}, 0);
        check_eq("rst_rx_word", rx_word, 0);
        check_eq("rst_ids", {tx_ch, rx_ch, tx_idx, rx_idx}, 0);
        reset = 1'b0;
        tick();

        // Two channels (0 and 2), two words each; mask change and re-start are ignored.
        snapshot();
        ch_enable = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_enable = 4'b1111;
        wait_rises(b_rise + 6, 100, "t2_reach_bit5");
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cycle_done(b_cycle + 1, 800, "t2_cycle_done_seen");
        repeat (30) tick();
        check_eq("t2_cycle_done_cnt", n_cycle - b_cycle, 1);
        check_eq("t2_frame_done_cnt", n_frame - b_frame, 2);
        check_eq("t2_rx_cnt", n_rx - b_rx, 4);
        check_eq("t2_tx_load_cnt", n_txl - b_txl, 4);
        check_eq("t2_sck_rises", n_rise - b_rise, 64);
        check_eq("t2_mosi_words", n_mosi - b_mosi, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_rx_word%0d", i), log_rx_word[b_rx + i], 16'h1234);
            check_eq($sformatf("t2_rx_ch%0d", i), log_rx_ch[b_rx + i], exp_ch[i]);
            check_eq($sformatf("t2_rx_idx%0d", i), log_rx_idx[b_rx + i], exp_idx[i]);
            check_eq($sformatf("t2_tx_ch%0d", i), log_tx_ch[b_txl + i], exp_ch[i]);
            check_eq($sformatf("t2_mosi%0d", i), log_mosi[b_mosi + i], 16'hA55A);
        end
        check_eq("t2_ss_fall_cnt", n_ssfall - b_ssfall, 2);
        check_eq("t2_ss_first", log_ss_ch[b_ssfall], 0);
        check_eq("t2_ss_second", log_ss_ch[b_ssfall + 1], 2);
        check_eq("t2_ss_low_set", ss_low_ever, 4'b0101);
        check_eq("t2_sck_high_max", hi_run_max, 2);
        check_eq("t2_sck_high_min", hi_run_min, 2);
        // 2-clock trailing low half + 2-clock GAP + 1 LOAD cycle.
        check_eq("t2_inframe_low_run", lo_run_max, 5);
        // 4 DESEL clocks plus the NEXT cycle that selects channel 2.
        check_eq("t2_desel_hi_run", log_hirun[b_hirun], 5);
        // Per frame: 2*(LOAD 1 + SHIFT 64) + GAP 2 + DESEL 4 + NEXT 1 = 137.
        check_eq("t2_busy_cycles", n_busy - b_busy, 274);
        check_eq("t2_busy_after", busy, 0);

        // Empty mask: cycle_done next cycle, nothing else.
        snapshot();
        ch_enable = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_cycle_done", cycle_done, 1);
        check_eq("t3_busy", busy, 0);
        check_eq("t3_ss_n", spi_ss_n, 4'hF);
        tick();
        check_eq("t3_cycle_done_drop", cycle_done, 0);
        repeat (5) tick();
        check_eq("t3_busy_cycles", n_busy - b_busy, 0);
        check_eq("t3_ss_low_cycles", n_sslow - b_sslow, 0);
        check_eq("t3_cycle_done_cnt", n_cycle - b_cycle, 1);

        // Reset during bit 7 of the first word.
        snapshot();
        ch_enable = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rises(b_rise + 8, 100, "t4_reach_bit7");
        reset = 1'b1;
        tick();
        check_eq("t4_ss_n", spi_ss_n, 4'hF);
        check_eq("t4_sck", spi_sck, 0);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_rx_valid", rx_valid, 0);
        reset = 1'b0;
        repeat (200) tick();
        check_eq("t4_rx_cnt", n_rx - b_rx, 0);
        check_eq("t4_frame_cnt", n_frame - b_frame, 0);
        check_eq("t4_cycle_cnt", n_cycle - b_cycle, 0);
        check_eq("t4_busy_after", busy, 0);

`ifdef SPI_SEQ_CONTINUOUS_EN
        // Continuous cycles on channel 3 only.
        snapshot();
        ch_enable  = 4'b1000;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cycle_done(b_cycle + 3, 1000, "t5_three_cycles");
        tick();
        continuous = 1'b0;
        wait_cycle_done(b_cycle + 4, 400, "t5_fourth_cycle");
        repeat (20) tick();
        check_eq("t5_cycle_cnt", n_cycle - b_cycle, 4);
        check_eq("t5_frame_cnt", n_frame - b_frame, 4);
        check_eq("t5_rx_cnt", n_rx - b_rx, 8);
        check_eq("t5_ss_fall_cnt", n_ssfall - b_ssfall, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t5_ss_ch%0d", i), log_ss_ch[b_ssfall + i], 3);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("t5_rx_ch%0d", i), log_rx_ch[b_rx + i], 3);
        check_eq("t5_hi_run_cnt", n_hirun - b_hirun, 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t5_desel_hi_run%0d", i), log_hirun[b_hirun + i], 5);
        check_eq("t5_busy_cycles", n_busy - b_busy, 548);
        check_eq("t5_busy_after", busy, 0);
`endif

        check_eq("ss_one_hot_violations", n_onehot_err, 0);
        check_eq("sck_without_ss", n_sck_noss, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/spi_channel_sequencer.md
SPI_CHANNEL_SEQUENCER -- requirements
Module: spi_channel_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of SPI slaves sharing SCK/MOSI/MISO (range 1..16).
REQ-002 SHALL have parameter WORD_W, default 16, bits per SPI word (range 8..32).
REQ-003 SHALL have parameter FRAME_WORDS, default 2, words per slave-select assertion (range 1..8).
REQ-004 SHALL have parameter CLK_DIV, default 2, SCK half-period in clock cycles (range 1..255).
REQ-005 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to run one cycle over enabled channels.
REQ-008 SHALL have port ch_enable, input, NUM_CH, per-channel enable mask.
REQ-009 SHALL have port tx_data, input, WORD_W, word to transmit; sampled in the cycle tx_load is high.
REQ-010 SHALL have port tx_load, output, 1, one-cycle pulse requesting tx_data for the current (tx_ch, tx_idx).
REQ-011 SHALL have ports tx_ch/rx_ch (output, clog2(NUM_CH)) and tx_idx/rx_idx (output, clog2(FRAME_WORDS), min 1), identifying the channel and word index.
REQ-012 SHALL have port rx_word, output, WORD_W, last received word; rx_valid, output, 1, one-cycle qualifier.
REQ-013 SHALL have ports spi_sck (output, 1), spi_mosi (output, 1), spi_miso (input, 1), spi_ss_n (output, NUM_CH, active-low).
REQ-014 SHALL have ports busy (output, 1), frame_done (output, 1, pulse per channel), cycle_done (output, 1, pulse per cycle).

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, GAP, DESEL, NEXT.
REQ-016 In IDLE, start SHALL latch ch_enable; subsequent mask changes are ignored until the next IDLE.
REQ-017 Start with latched mask zero SHALL pulse cycle_done the following cycle, with no SS or SCK activity and busy staying 0.
REQ-018 Start while busy SHALL be ignored.
REQ-019 Channels SHALL be visited in ascending index order, skipping disabled ones.
REQ-020 LOAD: spi_ss_n[ch] low, tx_load pulse one cycle, tx_data captured into the shift register; SHIFT entered next cycle.
REQ-021 SPI mode: CPOL=0, CPHA=1, MSB first; MOSI updates on SCK rising edge, MISO sampled on SCK falling edge.
REQ-022 Each bit SHALL take 2*CLK_DIV clocks (SCK high CLK_DIV, low CLK_DIV); a word takes exactly WORD_W*2*CLK_DIV clocks in SHIFT.
REQ-023 rx_valid SHALL pulse the cycle after the final falling edge of a word, with rx_word, rx_ch and rx_idx stable until the next rx_valid.
REQ-024 Between words of one frame, GAP SHALL hold SS low and SCK low for CLK_DIV clocks, then return to LOAD.
REQ-025 After the last word, DESEL SHALL drive all spi_ss_n high for 2*CLK_DIV clocks and pulse frame_done once.
REQ-026 NEXT SHALL select the next enabled channel, or, if none remains, pulse cycle_done and return to IDLE.
REQ-027 busy SHALL be 1 from the cycle after an accepted start until the cycle cycle_done is asserted, inclusive.
REQ-028 At most one spi_ss_n bit SHALL be low at any time.

Reset
REQ-029 Reset SHALL force IDLE; spi_ss_n all ones, spi_sck 0, spi_mosi 0, tx_load/rx_valid/frame_done/cycle_done/busy 0, rx_word 0, tx_ch/rx_ch/tx_idx/rx_idx 0.
REQ-030 Reset mid-transfer SHALL take effect next clock; the partial word SHALL be discarded with no rx_valid.

Configuration
REQ-031 Macro SPI_SEQ_CONTINUOUS_EN defined: an extra input continuous (1 bit) SHALL exist; when high at cycle_done, a new cycle starts next clock with a re-latched ch_enable.
REQ-032 Macro undefined: the continuous port SHALL be absent and every cycle requires start.

Verification
REQ-033 NUM_CH=4, FRAME_WORDS=2, CLK_DIV=2, mask 4'b0101, tx_data 16'hA55A, slave returns 16'h1234 -> SS[0] then SS[2] low, MOSI A55A MSB first, four rx_valid with 16'h1234, rx_ch 0,0,2,2, two frame_done, one cycle_done; SS[1], SS[3] stay high.
REQ-034 CLK_DIV=2 -> SCK period 4 clocks, exactly 16 rising edges per word, 2-clock SCK-low gap between the words of a frame.
REQ-035 mask 0, start -> cycle_done one cycle later, busy never 1, SS all high.
REQ-036 start repeated at bit 5 of the first word -> ignored; exactly one cycle_done.
REQ-037 reset at bit 7 of a word -> next clock SS all high, SCK 0, busy 0, no rx_valid.
REQ-038 SPI_SEQ_CONTINUOUS_EN, continuous=1, mask 4'b1000 -> back-to-back frames on SS[3], cycle_done each cycle, DESEL high time 4 clocks.
